// File: rtl/key_duty_ctrl_pkg.sv
// ============================================================================
// key_duty_ctrl_pkg : debounce state encodings and PWM period defaults
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package key_duty_ctrl_pkg;
  // Shared with the PWM LED driver so both stages agree on the period
  localparam int c_pwm_cnt_w  = 17;
  localparam int c_pwm_period = 90_000;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_press_f = 2'd1;
  localparam logic [1:0] c_st_pressed = 2'd2;
  localparam logic [1:0] c_st_rel_f   = 2'd3;
endpackage

`default_nettype wire

// File: rtl/key_duty_ctrl_debounce.sv
// ============================================================================
// key_debounce : 2-FF synchroniser plus press/release filter for one key
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import key_duty_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int                 c_cnt_w    = $clog2(DEB_CNT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CNT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;

  // Preset to released so a key held through reset is filtered afresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (!r_sync2) begin
          w_state_nxt = c_st_press_f;
          w_cnt_nxt   = '0;
        end
      end
      c_st_press_f: begin
        if (r_sync2) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_st_pressed;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      c_st_pressed: begin
        if (r_sync2) begin
          w_state_nxt = c_st_rel_f;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (!r_sync2) begin
          w_state_nxt = c_st_pressed;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
    endcase
  end

  // Single-cycle pulse on the accepting PRESS_F -> PRESSED transition
  always_comb begin
    press = 1'b0;
    if ((r_state == c_st_press_f) && !r_sync2 && (r_cnt == c_cnt_last))
      press = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/key_duty_ctrl.sv
// ============================================================================
// key_duty_ctrl : debounced up/down keys step a saturating PWM duty value
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_duty_ctrl
  import key_duty_ctrl_pkg::*;
#(
  parameter int CNT_W     = c_pwm_cnt_w,
  parameter int PERIOD    = c_pwm_period,
  parameter int STEP      = 10_000,
  parameter int DUTY_INIT = 50_000,
  parameter int DEB_CNT   = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  output logic [CNT_W-1:0] duty,
  output logic             duty_vld,
  output logic             at_max,
  output logic             at_min
);

  generate
    if ((PERIOD >= 2**CNT_W) || (STEP < 1) || (STEP > PERIOD) ||
        (DUTY_INIT < 0) || (DUTY_INIT > PERIOD) || (DEB_CNT < 2)) begin : g_param_check
      $error("key_duty_ctrl: illegal parameter combination");
    end
  endgenerate

  localparam logic [CNT_W:0]   c_period_x  = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   c_step_x    = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] c_period    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] c_step      = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] c_duty_init = CNT_W'(DUTY_INIT);

  logic             w_up_press;
  logic             w_dn_press;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_duty_nxt;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_up_n),
    .press (w_up_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_dn_n),
    .press (w_dn_press)
  );

  // One extra bit on the sum so a step near the top cannot wrap past zero
  assign w_sum = {1'b0, duty} + c_step_x;

  always_comb begin
    w_duty_nxt = duty;
    if (w_up_press && !w_dn_press) begin
      w_duty_nxt = (w_sum > c_period_x) ? c_period : w_sum[CNT_W-1:0];
    end else if (w_dn_press && !w_up_press) begin
      w_duty_nxt = (duty >= c_step) ? (duty - c_step) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= c_duty_init;
      duty_vld <= 1'b0;
      at_max   <= (c_duty_init == c_period);
      at_min   <= (c_duty_init == '0);
    end else begin
      duty     <= w_duty_nxt;
      duty_vld <= (w_duty_nxt != duty);
      at_max   <= (w_duty_nxt == c_period);
      at_min   <= (w_duty_nxt == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_duty_ctrl.sv
// ============================================================================
// tb_key_duty_ctrl : directed + randomized key presses against a duty model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_duty_ctrl;

  localparam int PERIOD = 90_000;
  localparam int STEP   = 10_000;
  localparam int DEB    = 8;
  localparam int INIT0  = 50_000;
  localparam int INIT1  = 5_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  up_n;
  logic [1:0]  dn_n;
  logic [16:0] duty0, duty1;
  logic        vld0, vld1, amax0, amax1, amin0, amin1;

  int errors = 0;
  int checks = 0;
  int vcnt0  = 0;
  int vcnt1  = 0;
  int mdl[2];

  always #5 clk = ~clk;

  key_duty_ctrl #(.CNT_W(17), .PERIOD(PERIOD), .STEP(STEP), .DUTY_INIT(INIT0), .DEB_CNT(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .key_up_n(up_n[0]), .key_dn_n(dn_n[0]),
    .duty(duty0), .duty_vld(vld0), .at_max(amax0), .at_min(amin0));

  key_duty_ctrl #(.CNT_W(17), .PERIOD(PERIOD), .STEP(STEP), .DUTY_INIT(INIT1), .DEB_CNT(DEB)) dut5 (
    .clk(clk), .rst_n(rst_n), .key_up_n(up_n[1]), .key_dn_n(dn_n[1]),
    .duty(duty1), .duty_vld(vld1), .at_max(amax1), .at_min(amin1));

  always @(posedge clk) begin
    if (vld0) vcnt0 <= vcnt0 + 1;
    if (vld1) vcnt1 <= vcnt1 + 1;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ref_duty(int d, bit up, bit dn);
    if (up && !dn) return (d + STEP > PERIOD) ? PERIOD : d + STEP;
    if (dn && !up) return (d >= STEP) ? d - STEP : 0;
    return d;
  endfunction

  function automatic int get_duty(int sel);
    return (sel == 1) ? int'(duty1) : int'(duty0);
  endfunction

  function automatic int get_vcnt(int sel);
    return (sel == 1) ? vcnt1 : vcnt0;
  endfunction

  task automatic drive(int sel, bit up, bit dn, logic lvl);
    if (up) up_n[sel] = lvl;
    if (dn) dn_n[sel] = lvl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    mdl[0] = INIT0;
    mdl[1] = INIT1;
    tick(2);
  endtask

  // Bouncy press/release; every low or high glitch is shorter than the filter
  task automatic press(int sel, bit up, bit dn, int hold, int bounce);
    int   v0, k, len, exp_d;
    logic lvl;
    v0 = get_vcnt(sel);
    k = 0;
    lvl = 1'b0;
    while (k < bounce) begin
      len = $urandom_range(1, 4);
      drive(sel, up, dn, lvl);
      tick(len);
      lvl = ~lvl;
      k += len;
    end
    drive(sel, up, dn, 1'b0);
    tick(hold);
    k = 0;
    lvl = 1'b1;
    while (k < bounce) begin
      len = $urandom_range(1, 4);
      drive(sel, up, dn, lvl);
      tick(len);
      lvl = ~lvl;
      k += len;
    end
    drive(sel, up, dn, 1'b1);
    tick(DEB + 8);
    exp_d = ref_duty(mdl[sel], up, dn);
    check("press_duty", get_duty(sel), exp_d);
    check("press_vld_count", get_vcnt(sel) - v0, (exp_d != mdl[sel]) ? 1 : 0);
    check("press_at_max", (sel == 1) ? amax1 : amax0, exp_d == PERIOD);
    check("press_at_min", (sel == 1) ? amin1 : amin0, exp_d == 0);
    mdl[sel] = exp_d;
  endtask

  initial begin
    int lat, v0;
    up_n = 2'b11;
    dn_n = 2'b11;
    do_reset();

    // Reset state and idle quiet period
    check("rst_duty", duty0, INIT0);
    check("rst_vld", vld0, 0);
    check("rst_at_max", amax0, 0);
    check("rst_at_min", amin0, 0);
    check("rst_duty5", duty1, INIT1);
    tick(100);
    check("idle_duty", duty0, INIT0);
    check("idle_vld_count", vcnt0, 0);

    // Clean press, then a long hold must not auto-repeat
    press(0, 1'b1, 1'b0, 20, 0);
    v0 = vcnt0;
    press(0, 1'b1, 1'b0, 220, 0);
    v0 = vcnt0 - v0;
    check("second_press_once", v0, (mdl[0] != 60_000 + STEP) ? 0 : 1);

    // Regular 3-cycle bounce, then measure latency from stable low
    do_reset();
    v0 = vcnt0;
    for (int s = 0; s < 14; s++) begin
      up_n[0] = (s % 2 == 1);
      tick(3);
    end
    up_n[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (vld0 && lat == 0) lat = i;
    end
    check("bounce_latency", lat, 2 + DEB + 1);
    up_n[0] = 1'b1;
    tick(DEB + 8);
    check("bounce_vld_count", vcnt0 - v0, 1);
    check("bounce_duty", duty0, INIT0 + STEP);

    // Saturation at both ends
    do_reset();
    for (int i = 0; i < 5; i++) press(0, 1'b1, 1'b0, 15, 0);
    check("sat_top", duty0, PERIOD);
    for (int i = 0; i < 10; i++) press(0, 1'b0, 1'b1, 15, 0);
    check("sat_bottom", duty0, 0);

    // Non-multiple start value clamps to zero, then steps up
    press(1, 1'b0, 1'b1, 15, 0);
    press(1, 1'b1, 1'b0, 15, 0);
    check("nonmult_final", duty1, 10_000);

    // Both keys accepted in the same cycle are ignored
    do_reset();
    press(0, 1'b1, 1'b1, 20, 0);

    // Reset during PRESS_F with key held: fresh full filter after release
    up_n[0] = 1'b0;
    tick(6);
    rst_n = 1'b0;
    #2;
    check("midrst_duty", duty0, INIT0);
    check("midrst_vld", vld0, 0);
    tick(2);
    rst_n = 1'b1;
    mdl[0] = INIT0;
    mdl[1] = INIT1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (vld0 && lat == 0) lat = i;
    end
    check("midrst_relatency", lat, 2 + DEB + 1);
    up_n[0] = 1'b1;
    tick(DEB + 8);
    mdl[0] = ref_duty(mdl[0], 1'b1, 1'b0);
    check("midrst_duty_after", duty0, mdl[0]);

    // Randomized bouncy presses against the model
    for (int i = 0; i < 16; i++) begin
      bit up;
      up = 1'($urandom_range(0, 1));
      press(0, up, !up, $urandom_range(12, 30), $urandom_range(0, 20));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
